// File: rtl/bc_pkg.sv
// bc_pkg: state encoding, control-vector layout and select/ALU codes for bloco_controle.
// Rev 1.0
`default_nettype none

package bc_pkg;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    LOAD = 4'd1,
    Q1   = 4'd2,
    Q2   = 4'd3,
    Q3   = 4'd4,
    Q4   = 4'd5,
    L1   = 4'd6,
    L2   = 4'd7,
    DONE = 4'd8
  } state_t;

  // mux0 codes 00 and 01 both pick a; SEL0_A uses 00
  localparam logic [1:0] SEL0_A    = 2'b00;
  localparam logic [1:0] SEL0_B    = 2'b10;
  localparam logic [1:0] SEL0_C    = 2'b11;
  localparam logic [1:0] SEL1_MUX0 = 2'b00;
  localparam logic [1:0] SEL1_S    = 2'b10;
  localparam logic [1:0] SEL1_H    = 2'b11;
  localparam logic [1:0] SEL2_X    = 2'b00;
  localparam logic [1:0] SEL2_MUX0 = 2'b01;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_MUL = 1'b1;

  typedef struct packed {
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       h;
    logic       lx;
    logic       ls;
    logic       lh;
    logic       busy;
    logic       done;
  } ctrl_t;

  localparam ctrl_t CTRL_OFF = '0;

endpackage

`default_nettype wire

// File: rtl/bc_decode.sv
// bc_decode: pure state-to-control-vector decoder for bloco_controle.
// Rev 1.0
`default_nettype none

module bc_decode
  import bc_pkg::*;
(
  input  state_t i_state,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = CTRL_OFF;
    case (i_state)
      LOAD: begin
        o_ctrl.lx   = 1'b1;
        o_ctrl.busy = 1'b1;
      end
      Q1: begin
        o_ctrl.m0   = SEL0_A;
        o_ctrl.m1   = SEL1_MUX0;
        o_ctrl.m2   = SEL2_X;
        o_ctrl.h    = ALU_MUL;
        o_ctrl.ls   = 1'b1;
        o_ctrl.busy = 1'b1;
      end
      Q2: begin
        o_ctrl.m0   = SEL0_B;
        o_ctrl.m1   = SEL1_S;
        o_ctrl.m2   = SEL2_MUX0;
        o_ctrl.h    = ALU_ADD;
        o_ctrl.ls   = 1'b1;
        o_ctrl.busy = 1'b1;
      end
      Q3: begin
        o_ctrl.m1   = SEL1_S;
        o_ctrl.m2   = SEL2_X;
        o_ctrl.h    = ALU_MUL;
        o_ctrl.ls   = 1'b1;
        o_ctrl.busy = 1'b1;
      end
      Q4: begin
        o_ctrl.m0   = SEL0_C;
        o_ctrl.m1   = SEL1_S;
        o_ctrl.m2   = SEL2_MUX0;
        o_ctrl.h    = ALU_ADD;
        o_ctrl.ls   = 1'b1;
        o_ctrl.busy = 1'b1;
      end
      // Linear path parks a*X in H so S is only written with the final result
      L1: begin
        o_ctrl.m0   = SEL0_A;
        o_ctrl.m1   = SEL1_MUX0;
        o_ctrl.m2   = SEL2_X;
        o_ctrl.h    = ALU_MUL;
        o_ctrl.lh   = 1'b1;
        o_ctrl.busy = 1'b1;
      end
      L2: begin
        o_ctrl.m0   = SEL0_C;
        o_ctrl.m1   = SEL1_H;
        o_ctrl.m2   = SEL2_MUX0;
        o_ctrl.h    = ALU_ADD;
        o_ctrl.ls   = 1'b1;
        o_ctrl.busy = 1'b1;
      end
      DONE: begin
        o_ctrl.done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bloco_controle.sv
// bloco_controle: Moore controller sequencing the datapath for a*x^2+b*x+c or a*x+c.
// Rev 1.0
`default_nettype none

module bloco_controle
  import bc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       op,
  output logic [1:0] m0,
  output logic [1:0] m1,
  output logic [1:0] m2,
  output logic       h,
  output logic       lx,
  output logic       ls,
  output logic       lh,
  output logic       busy,
  output logic       done
);

  state_t r_state;
  state_t w_next;
  logic   r_op;
  ctrl_t  w_ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_op <= op;
      end
    end
  end

  // start is only looked at in IDLE, so requests while busy or in DONE are dropped
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = start ? LOAD : IDLE;
      LOAD:    w_next = r_op ? L1 : Q1;
      Q1:      w_next = Q2;
      Q2:      w_next = Q3;
      Q3:      w_next = Q4;
      Q4:      w_next = DONE;
      L1:      w_next = L2;
      L2:      w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  bc_decode u_decode (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  assign m0   = w_ctrl.m0;
  assign m1   = w_ctrl.m1;
  assign m2   = w_ctrl.m2;
  assign h    = w_ctrl.h;
  assign lx   = w_ctrl.lx;
  assign ls   = w_ctrl.ls;
  assign lh   = w_ctrl.lh;
  assign busy = w_ctrl.busy;
  assign done = w_ctrl.done;

endmodule

`default_nettype wire

// File: tb/tb_bloco_controle.sv
// tb_bloco_controle: directed bench for bloco_controle with a small behavioural datapath.
// Rev 1.0
`default_nettype none

module tb_bloco_controle;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       op;
  logic [1:0] m0, m1, m2;
  logic       h, lx, ls, lh, busy, done;

  bloco_controle dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .m0    (m0),
    .m1    (m1),
    .m2    (m2),
    .h     (h),
    .lx    (lx),
    .ls    (ls),
    .lh    (lh),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: S is the result register read as resultado
  logic signed [15:0] a = '0, b = '0, c = '0, x = '0;
  logic signed [15:0] r_x = '0, r_s = '0, r_h = '0;
  logic signed [15:0] w_mux0, w_in1, w_in2, w_alu;
  logic signed [31:0] w_prod;

  always_comb begin
    w_mux0 = (m0 == 2'b10) ? b : (m0 == 2'b11) ? c : a;
    case (m1)
      2'b00:   w_in1 = w_mux0;
      2'b01:   w_in1 = r_x;
      2'b10:   w_in1 = r_s;
      default: w_in1 = r_h;
    endcase
    case (m2)
      2'b00:   w_in2 = r_x;
      2'b01:   w_in2 = w_mux0;
      2'b10:   w_in2 = r_s;
      default: w_in2 = r_h;
    endcase
    w_prod = w_in1 * w_in2;
    w_alu  = h ? w_prod[15:0] : (w_in1 + w_in2);
  end

  always @(posedge clk) begin
    if (lx) r_x <= x;
    if (ls) r_s <= w_alu;
    if (lh) r_h <= w_alu;
  end

  logic [11:0] w_ctrl;
  assign w_ctrl = {m0, m1, m2, h, lx, ls, lh, busy, done};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // {m0,m1,m2,h,lx,ls,lh,busy,done} expected j cycles after the start edge (j=0 is LOAD)
  function automatic logic [11:0] exp_ctrl(input logic o, input int j);
    logic [11:0] v;
    v = 12'b00_00_00_0_0_0_0_0_0;
    if (!o) begin
      case (j)
        0: v = 12'b00_00_00_0_1_0_0_1_0;
        1: v = 12'b00_00_00_1_0_1_0_1_0;
        2: v = 12'b10_10_01_0_0_1_0_1_0;
        3: v = 12'b00_10_00_1_0_1_0_1_0;
        4: v = 12'b11_10_01_0_0_1_0_1_0;
        5: v = 12'b00_00_00_0_0_0_0_0_1;
        default: v = 12'b0;
      endcase
    end else begin
      case (j)
        0: v = 12'b00_00_00_0_1_0_0_1_0;
        1: v = 12'b00_00_00_1_0_0_1_1_0;
        2: v = 12'b11_11_01_0_0_1_0_1_0;
        3: v = 12'b00_00_00_0_0_0_0_0_1;
        default: v = 12'b0;
      endcase
    end
    return v;
  endfunction

  typedef struct {
    logic               op;
    logic signed [15:0] a, b, c, x;
    logic signed [15:0] res;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at #1 after an edge with the controller in IDLE
  task automatic run_vec(input vec_t v, input string tag);
    int d;
    int nbusy;
    d = v.op ? 3 : 5;
    nbusy = 0;
    a = v.a; b = v.b; c = v.c; x = v.x; op = v.op;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j <= d + 1; j++) begin
      chk($sformatf("%s ctrl j=%0d", tag, j), int'(w_ctrl), int'(exp_ctrl(v.op, j)));
      if (busy) nbusy++;
      if (j == d) chk($sformatf("%s resultado", tag), int'(r_s), int'(v.res));
      step();
    end
    chk($sformatf("%s busy cycles", tag), nbusy, d);
  endtask

  initial begin
    int ndone;
    int last;
    int seen;

    // 200*200 = 40000; 40000*200 = 8000000 = 122*65536 + 4608 -> 0x1200 after wrap
    vecs[0] = '{op: 1'b0, a: 16'sd2,   b: 16'sd3, c: 16'sd4,  x: 16'sd5,   res: 16'sd69};
    vecs[1] = '{op: 1'b0, a: -16'sd1,  b: 16'sd0, c: 16'sd7,  x: -16'sd3,  res: -16'sd2};
    vecs[2] = '{op: 1'b1, a: 16'sd3,   b: 16'sd0, c: 16'sd10, x: -16'sd4,  res: -16'sd2};
    vecs[3] = '{op: 1'b0, a: 16'sd200, b: 16'sd0, c: 16'sd0,  x: 16'sd200, res: 16'sd4608};
    vecs[4] = '{op: 1'b1, a: -16'sd7,  b: 16'sd0, c: -16'sd5, x: 16'sd6,   res: -16'sd47};

    rst_n = 1'b0;
    start = 1'b1;
    op    = 1'b1;
    #2;
    chk("reset ctrl async", int'(w_ctrl), 0);
    step();
    step();
    chk("reset ctrl held", int'(w_ctrl), 0);
    start = 1'b0;
    op    = 1'b0;
    rst_n = 1'b1;
    step();
    chk("idle ctrl", int'(w_ctrl), 0);

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // start held high: starts at edges 0,7,14,21 give done at cycles 5,12,19,26
    a = 16'sd2; b = 16'sd3; c = 16'sd4; x = 16'sd5; op = 1'b0;
    start = 1'b1;
    ndone = 0;
    last  = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      step();
      if (done) begin
        if (last < 0) chk("b2b first done", cyc, 5);
        else          chk("b2b done interval", cyc - last, 7);
        chk("b2b resultado", int'(r_s), 69);
        last = cyc;
        ndone++;
      end
    end
    chk("b2b done count", ndone, 4);
    start = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk("b2b drain done", seen, 1);
    step();
    chk("b2b back to idle", int'(w_ctrl), 0);

    // reset during Q2
    a = 16'sd2; b = 16'sd3; c = 16'sd4; x = 16'sd5; op = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("pre-reset Q2 ctrl", int'(w_ctrl), int'(exp_ctrl(1'b0, 2)));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid-op reset ctrl", int'(w_ctrl), 0);
    step();
    chk("mid-op reset held", int'(w_ctrl), 0);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (done || busy) seen = 1;
    end
    chk("no done after reset", seen, 0);
    run_vec(vecs[0], "post-reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
